// File: rtl/booth_divider_seq.sv
// -----------------------------------------------------------------------------
// booth_divider_seq
//
// Sequential signed divider. It is the inverse of the 8x8 signed Booth/Wallace
// multiplier: a DW-bit dividend (product width) is divided by a VW-bit divisor
// (operand width). The result is a DW-bit quotient, truncated toward zero, and
// a VW-bit remainder whose sign follows the dividend.
//
// Algorithm: radix-2 restoring division on magnitudes. The unit produces one
// quotient bit per clock and applies the sign correction in a final state.
//
// States:
//   IDLE -> LOAD -> CALC (x DW, or x VW with skip) -> SIGN -> IDLE
//
// Latency: done rises DW+2 edges after the accepting edge.
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   start      request, accepted only while busy=0
//   dividend   signed DW-bit dividend
//   divisor    signed VW-bit divisor
//   busy       high from the accepting edge until the result edge
//   done       one-cycle pulse, results valid
//   quotient   signed DW-bit quotient (held until the next result)
//   remainder  signed VW-bit remainder (held until the next result)
//   div_zero   divisor was zero
//   ovf        quotient overflowed (-2^(DW-1) / -1)
//
// Optional build macro:
//   DIV_SKIP_HI_EN  when |dividend| < 2^VW, only VW quotient bits are
//                   iterated, so latency becomes VW+2. Without the macro,
//                   latency is always DW+2.
// -----------------------------------------------------------------------------
module booth_divider_seq #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_zero,
  output logic          ovf
);

  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_SIGN
  } state_e;

  state_e        state_q,     state_d;
  logic [DW-1:0] dvd_q,       dvd_d;       // latched raw dividend
  logic [VW-1:0] dvs_q,       dvs_d;       // latched raw divisor
  logic [DW-1:0] dq_q,        dq_d;        // dividend bits out at MSB, quotient bits in at LSB
  logic [VW-1:0] dvs_mag_q,   dvs_mag_d;
  logic [VW:0]   pr_q,        pr_d;        // partial remainder
  logic [CW-1:0] cnt_q,       cnt_d;
  logic          q_neg_q,     q_neg_d;
  logic          r_neg_q,     r_neg_d;
  logic          busy_q,      busy_d;
  logic          done_q,      done_d;
  logic [DW-1:0] quotient_q,  quotient_d;
  logic [VW-1:0] remainder_q, remainder_d;
  logic          div_zero_q,  div_zero_d;
  logic          ovf_q,       ovf_d;

  // Datapath helpers
  logic [DW-1:0] dvd_mag;
  logic [VW-1:0] dvs_mag;
  logic [VW:0]   pr_sh;
  logic [VW+1:0] diff;

  // Unary minus on an unsigned vector gives two's complement mod 2^width.
  // For the most negative value this yields the correct unsigned magnitude.
  assign dvd_mag = dvd_q[DW-1] ? -dvd_q : dvd_q;
  assign dvs_mag = dvs_q[VW-1] ? -dvs_q : dvs_q;

  // Shift the next dividend bit into the partial remainder, then trial-subtract.
  // The extra top bit of diff is the borrow: set means the result is negative.
  assign pr_sh = {pr_q[VW-1:0], dq_q[DW-1]};
  assign diff  = {1'b0, pr_sh} - {2'b00, dvs_mag_q};

  always_comb begin
    // NOTE: every signal gets a default here so that no path through the
    // case statement leaves one unassigned, which would infer a latch.
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    dq_d        = dq_q;
    dvs_mag_d   = dvs_mag_q;
    pr_d        = pr_q;
    cnt_d       = cnt_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    ovf_d       = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        dq_d      = dvd_mag;
        dvs_mag_d = dvs_mag;
        q_neg_d   = dvd_q[DW-1] ^ dvs_q[VW-1];
        r_neg_d   = dvd_q[DW-1];
        pr_d      = '0;
        cnt_d     = CW'(DW - 1);
`ifdef DIV_SKIP_HI_EN
        // A small dividend only needs VW iterations. Pre-aligning its low VW
        // bits to the top of the shift register means the zeros below them
        // become the cleared upper quotient bits once VW shifts have run.
        // A zero divisor keeps the full latency.
        if ((dvs_q != '0) && (dvd_mag[DW-1:VW] == '0)) begin
          dq_d  = dvd_mag << (DW - VW);
          cnt_d = CW'(VW - 1);
        end
`endif
        state_d = S_CALC;
      end

      S_CALC: begin
        if (diff[VW+1]) begin
          pr_d = pr_sh;                      // restore
          dq_d = {dq_q[DW-2:0], 1'b0};
        end else begin
          pr_d = diff[VW:0];
          dq_d = {dq_q[DW-2:0], 1'b1};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = S_SIGN;
        end
      end

      S_SIGN: begin
        if (dvs_q == '0) begin
          div_zero_d  = 1'b1;
          ovf_d       = 1'b0;
          quotient_d  = dvd_q[DW-1] ? {1'b1, {(DW-1){1'b0}}}
                                    : {1'b0, {(DW-1){1'b1}}};
          remainder_d = dvd_q[VW-1:0];
        end else begin
          div_zero_d  = 1'b0;
          quotient_d  = q_neg_q ? -dq_q : dq_q;
          remainder_d = r_neg_q ? -pr_q[VW-1:0] : pr_q[VW-1:0];
          // Only a positive result can reach 2^(DW-1). That case is exactly
          // -2^(DW-1) / -1, and the value wraps to -2^(DW-1).
          ovf_d       = ~q_neg_q & dq_q[DW-1];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its _d value from before the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      dq_q        <= '0;
      dvs_mag_q   <= '0;
      pr_q        <= '0;
      cnt_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      dq_q        <= dq_d;
      dvs_mag_q   <= dvs_mag_d;
      pr_q        <= pr_d;
      cnt_q       <= cnt_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      ovf_q       <= ovf_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;
  assign ovf       = ovf_q;

endmodule
